// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scanning multiplexer: mode encodings and the
// next-enabled-channel search used by scan_next_sel.
package scan_mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_HOLD   = 2'd2;

  // Upper bound on channel count handled by find_next; CHANNELS must not exceed it.
  localparam int unsigned MaxSelW     = 6;
  localparam int unsigned MaxChannels = 1 << MaxSelW;

  typedef struct packed {
    logic [MaxSelW-1:0] idx;
    logic               wrap;
    logic               any_en;
  } next_sel_t;

  // Searches cur+1 .. n-1, then 0 .. cur for the first set mask bit. With no bit
  // set, idx stays at cur and any_en is low. wrap marks idx <= cur, which covers
  // a lone enabled channel finding itself.
  function automatic next_sel_t find_next(input logic [MaxSelW-1:0]     cur,
                                          input logic [MaxChannels-1:0] mask,
                                          input int unsigned            n);
    next_sel_t   res;
    logic [31:0] j;
    logic        found;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MaxChannels; i++) begin
      j = 32'(cur) + i;
      if (j >= n) j = j - n;
      if ((i <= n) && !found && mask[j[MaxSelW-1:0]]) begin
        found   = 1'b1;
        res.idx = j[MaxSelW-1:0];
      end
    end
    if (!found) res.idx = cur;
    res.any_en = found;
    res.wrap   = found && (res.idx <= cur);
    return res;
  endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Combinational finder for the next enabled channel after cur_sel_i, with a flag
// for wrapping past the highest channel.
module scan_next_sel
  import scan_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]    cur_sel_i,
  input  logic [CHANNELS-1:0] en_mask_i,
  output logic [SEL_W-1:0]    next_sel_o,
  output logic                wrap_o,
  output logic                any_en_o
);

  next_sel_t res;

  // Single-cycle search over all channel positions.
  always_comb begin
    res = find_next(MaxSelW'(cur_sel_i), MaxChannels'(en_mask_i), CHANNELS);
  end

  assign next_sel_o = SEL_W'(res.idx);
  assign wrap_o     = res.wrap;
  assign any_en_o   = res.any_en;

endmodule

// File: rtl/scan_mux_n.sv
// N-channel, W-bit registered multiplexer with manual select, auto-scan with a
// programmable dwell, and hold. Outputs update one edge after inputs are sampled.
module scan_mux_n
  import scan_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned SEL_W    = $clog2(CHANNELS),
  parameter int unsigned DWELL_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic [CHANNELS-1:0]       en_mask,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      valid_out,
  output logic                      wrap_out
);

  // Pad mask and data to the full select range so any sel_in indexes safely;
  // padded channels read as disabled with zero data.
  localparam int unsigned NPad = 1 << SEL_W;
  localparam int unsigned PadW = NPad * WIDTH;

  logic [NPad-1:0] mask_pad;
  logic [PadW-1:0] data_pad;

  assign mask_pad = NPad'(en_mask);
  assign data_pad = PadW'(data_in);

  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

  logic [SEL_W-1:0] next_sel;
  logic             next_wrap;
  logic             any_en;
  logic             sel_in_range;
  logic             manual_ok;

  if (NPad == CHANNELS) begin : g_full_range
    assign sel_in_range = 1'b1;
  end else begin : g_part_range
    assign sel_in_range = (sel_in < SEL_W'(CHANNELS));
  end

  assign manual_ok = sel_in_range & mask_pad[sel_in];

  scan_next_sel #(
    .CHANNELS (CHANNELS)
  ) u_next_sel (
    .cur_sel_i  (cur_sel_q),
    .en_mask_i  (en_mask),
    .next_sel_o (next_sel),
    .wrap_o     (next_wrap),
    .any_en_o   (any_en)
  );

  // Mode decode and next-state for outputs, scan pointer and dwell counter.
  always_comb begin
    data_d      = data_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    wrap_d      = 1'b0;
    cur_sel_d   = cur_sel_q;
    dwell_cnt_d = dwell_cnt_q;
    case (mode)
      MODE_MANUAL: begin
        sel_d       = sel_in;
        valid_d     = manual_ok;
        data_d      = manual_ok ? data_pad[sel_in*WIDTH +: WIDTH] : '0;
        dwell_cnt_d = '0;
        if (sel_in_range) cur_sel_d = sel_in;
      end
      MODE_AUTO: begin
        sel_d   = cur_sel_q;
        valid_d = mask_pad[cur_sel_q];
        data_d  = any_en ? data_pad[cur_sel_q*WIDTH +: WIDTH] : '0;
        // Equality only: a count above a newly lowered dwell runs on and wraps.
        if (dwell_cnt_q == dwell) begin
          dwell_cnt_d = '0;
          if (any_en) begin
            cur_sel_d = next_sel;
            wrap_d    = next_wrap;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        // HOLD and the reserved encoding freeze everything; wrap_d already low.
      end
    endcase
  end

  // State register with synchronous reset taking priority over every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
      cur_sel_q   <= '0;
      dwell_cnt_q <= '0;
    end else begin
      data_q      <= data_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
      cur_sel_q   <= cur_sel_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign data_out  = data_q;
  assign sel_out   = sel_q;
  assign valid_out = valid_q;
  assign wrap_out  = wrap_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// Scoreboard bench for scan_mux_n: stimulus pushes hand-computed expectations
// tagged with the edge they belong to; a monitor pops and compares them.
module tb_scan_mux_n;
  import scan_mux_pkg::*;

  localparam int unsigned CH = 8;
  localparam int unsigned W  = 1;
  localparam int unsigned SW = 3;
  localparam int unsigned DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic [SW-1:0]     sel_in;
  logic [DW-1:0]     dwell;
  logic [CH-1:0]     en_mask;
  logic [CH*W-1:0]   data_in;

  logic [W-1:0]      d8, d6;
  logic [SW-1:0]     s8, s6;
  logic              v8, v6, w8, w6;

  always #5 clk = ~clk;

  scan_mux_n #(
    .CHANNELS (8),
    .WIDTH    (1),
    .DWELL_W  (8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .mode      (mode),
    .sel_in    (sel_in),
    .dwell     (dwell),
    .en_mask   (en_mask),
    .data_out  (d8),
    .sel_out   (s8),
    .valid_out (v8),
    .wrap_out  (w8)
  );

  scan_mux_n #(
    .CHANNELS (6),
    .WIDTH    (1),
    .DWELL_W  (8)
  ) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in[5:0]),
    .mode      (mode),
    .sel_in    (sel_in),
    .dwell     (dwell),
    .en_mask   (en_mask[5:0]),
    .data_out  (d6),
    .sel_out   (s6),
    .valid_out (v6),
    .wrap_out  (w6)
  );

  typedef struct {
    int          tgt;
    int          dut;
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic        valid;
    logic        wrap;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  logic [7:0] dpat;
  logic [2:0] auto_sel [11] = '{0, 0, 0, 2, 2, 2, 5, 5, 5, 0, 0};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare every expectation whose edge has already happened.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      exp_t e;
      logic [W-1:0]  ad;
      logic [SW-1:0] as;
      logic          av, aw;
      e = sb.pop_front();
      if (e.dut == 1) begin
        ad = d6; as = s6; av = v6; aw = w6;
      end else begin
        ad = d8; as = s8; av = v8; aw = w8;
      end
      n_vec++;
      if (ad !== e.data || as !== e.sel || av !== e.valid || aw !== e.wrap) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got data=%0h sel=%0d valid=%0b wrap=%0b, required data=%0h sel=%0d valid=%0b wrap=%0b",
                 e.name, cyc, ad, as, av, aw, e.data, e.sel, e.valid, e.wrap);
      end
    end
  end

  task automatic push(input int dut, input logic [W-1:0] ed, input logic [SW-1:0] es,
                      input logic ev, input logic ew, input string nm);
    exp_t e;
    e.tgt = cyc + 1; e.dut = dut; e.data = ed; e.sel = es;
    e.valid = ev; e.wrap = ew; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [1:0] m, input logic [SW-1:0] s,
                      input logic [DW-1:0] dw, input logic [CH-1:0] mk,
                      input logic [CH*W-1:0] din, input logic [W-1:0] ed,
                      input logic [SW-1:0] es, input logic ev, input logic ew,
                      input string nm);
    @(negedge clk);
    rst = r; mode = m; sel_in = s; dwell = dw; en_mask = mk; data_in = din;
    push(0, ed, es, ev, ew, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dpat    = 8'b1010_0110;
    rst     = 1'b1;
    mode    = MODE_MANUAL;
    sel_in  = '0;
    dwell   = '0;
    en_mask = 8'hFF;
    data_in = dpat;

    step(1, MODE_MANUAL, 0, 0, 8'hFF, dpat, 0, 0, 0, 0, "reset");

    // Manual select, masking and out-of-range select.
    step(0, MODE_MANUAL, 1, 0, 8'hFF, dpat, 1, 1, 1, 0, "man_sel1");
    step(0, MODE_MANUAL, 0, 0, 8'hFF, dpat, 0, 0, 1, 0, "man_sel0");
    step(0, MODE_MANUAL, 5, 0, 8'hFF, dpat, 1, 5, 1, 0, "man_sel5");
    step(0, MODE_MANUAL, 1, 0, 8'hFD, dpat, 0, 1, 0, 0, "man_masked");
    step(0, MODE_MANUAL, 7, 0, 8'hFF, dpat, 1, 7, 1, 0, "man_sel7");
    push(1, 0, 7, 0, 0, "man_oor_ch6");

    // Auto scan, dwell=2, channels 0/2/5.
    step(0, MODE_MANUAL, 0, 0, 8'h25, dpat, 0, 0, 1, 0, "auto_setup");
    for (int k = 0; k < 11; k++) begin
      step(0, MODE_AUTO, 0, 2, 8'h25, dpat, dpat[auto_sel[k]], auto_sel[k], 1, (k == 8),
           "auto_scan");
    end

    // Single enabled channel, then empty mask.
    step(0, MODE_MANUAL, 4, 0, 8'h10, 8'hFF, 1, 4, 1, 0, "man_sel4");
    for (int k = 0; k < 3; k++) step(0, MODE_AUTO, 0, 0, 8'h10, 8'hFF, 1, 4, 1, 1, "auto_single");
    for (int k = 0; k < 2; k++) step(0, MODE_AUTO, 0, 0, 8'h00, 8'hFF, 0, 4, 0, 0, "auto_nomask");

    // Hold mid-dwell; data changes underneath must not show.
    step(0, MODE_MANUAL, 2, 0, 8'hFF, dpat, 1, 2, 1, 0, "man_sel2");
    for (int k = 0; k < 2; k++) step(0, MODE_AUTO, 0, 3, 8'hFF, dpat, 1, 2, 1, 0, "auto_pre_hold");
    for (int k = 0; k < 5; k++) step(0, MODE_HOLD, 0, 3, 8'hFF, 8'h00, 1, 2, 1, 0, "hold");
    for (int k = 0; k < 2; k++) step(0, MODE_AUTO, 0, 3, 8'hFF, dpat, 1, 2, 1, 0, "auto_post_hold");
    step(0, MODE_AUTO, 0, 3, 8'hFF, dpat, 0, 3, 1, 0, "auto_adv3");

    // Reset mid-scan, then restart from channel 0.
    step(0, MODE_MANUAL, 5, 0, 8'hFF, dpat, 1, 5, 1, 0, "man_sel5b");
    step(0, MODE_AUTO, 0, 3, 8'hFF, dpat, 1, 5, 1, 0, "auto_ch5");
    step(1, MODE_AUTO, 0, 3, 8'hFF, dpat, 0, 0, 0, 0, "rst_mid_scan");
    for (int k = 0; k < 4; k++) step(0, MODE_AUTO, 0, 3, 8'hFF, dpat, 0, 0, 1, 0, "auto_restart");
    step(0, MODE_AUTO, 0, 3, 8'hFF, dpat, 1, 1, 1, 0, "auto_restart_adv");

    // Dwell lowered below the running count: count wraps through 256 then advances.
    for (int k = 0; k < 256; k++) step(0, MODE_AUTO, 0, 0, 8'hFF, dpat, 1, 1, 1, 0, "dwell_wrap");
    step(0, MODE_AUTO, 0, 0, 8'hFF, dpat, 1, 2, 1, 0, "dwell_wrap_adv");

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_mux_n.md
Name: scan_mux_n

Overview:
- Parametrised N-channel, W-bit registered multiplexer; generalises the team's 8:1 single-bit combinational mux.
- Adds three modes:
  - manual select;
  - auto-scan, which steps through enabled channels with a programmable dwell time;
  - hold.
- Adds a per-channel enable mask, a valid flag and a scan-wrap pulse.
- Sits between the tile's dedicated inputs and its outputs, feeding downstream sampling/serialising logic.

Parameters:
- CHANNELS, 8: number of input channels; must be at least 2.
- WIDTH, 1: bits per channel.
- SEL_W, $clog2(CHANNELS): select width; derived, do not override.
- DWELL_W, 8: width of the dwell counter and of the dwell input.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- mode  in  2  0=MANUAL, 1=AUTO, 2=HOLD, 3=reserved (treated as HOLD).
- sel_in  in  SEL_W  channel select used in MANUAL.
- dwell  in  DWELL_W  in AUTO, each channel is presented for dwell+1 cycles.
- en_mask  in  CHANNELS  1 = channel participates; applies to MANUAL and AUTO.
- data_out  out  WIDTH  registered selected data.
- sel_out  out  SEL_W  channel index that data_out was taken from.
- valid_out  out  1  data_out holds legal enabled-channel data.
- wrap_out  out  1  one-cycle pulse when AUTO advance wraps around.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset (rst=1 at an edge) forces:
  - data_out=0, sel_out=0, valid_out=0, wrap_out=0;
  - internal cur_sel=0, dwell_cnt=0.
  - rst has priority over every other input, including mid-scan.
- Latency: one cycle in every mode. Inputs sampled at edge k appear on outputs after edge k.
- MANUAL:
  - If sel_in < CHANNELS and en_mask[sel_in]=1: data_out<=data_in[sel_in], sel_out<=sel_in, valid_out<=1.
  - Otherwise (out-of-range select, or masked channel): data_out<=0, sel_out<=sel_in truncated as is, valid_out<=0.
  - Each edge: cur_sel<=sel_in (when in range), dwell_cnt<=0, wrap_out<=0.
- AUTO:
  - Each edge: data_out<=data_in[cur_sel], sel_out<=cur_sel, valid_out<=en_mask[cur_sel].
  - If dwell_cnt==dwell:
    - dwell_cnt<=0;
    - cur_sel<=next enabled index, searching cur_sel+1 … CHANNELS-1, then 0 … cur_sel, with modular wrap;
    - wrap_out<=1 if that next index <= cur_sel (this includes a single enabled channel re-selecting itself);
    - otherwise wrap_out<=0.
  - Else: dwell_cnt<=dwell_cnt+1, wrap_out<=0.
  - dwell=0 advances every cycle.
  - A currently masked cur_sel advances at the dwell boundary like any other channel.
  - en_mask all zero: cur_sel holds, valid_out<=0, data_out<=0, wrap_out<=0, dwell_cnt still counts and wraps.
- HOLD:
  - data_out, sel_out, valid_out, cur_sel and dwell_cnt all keep their values; wrap_out<=0.
- Mode transitions:
  - MANUAL→AUTO: scanning starts at the last manual cur_sel with dwell_cnt=0.
  - HOLD→AUTO: resumes from the frozen cur_sel/dwell_cnt.
  - Changing dwell mid-count: the comparison uses the new value. If dwell_cnt > dwell, the count continues upward and wraps through 2^DWELL_W; this is legal and must not lock up.
- Arithmetic: dwell_cnt is DWELL_W bits, unsigned, wrapping. Next-index search is combinational over CHANNELS positions; there is no multi-cycle search.

Decomposition:
- Shared package scan_mux_pkg holds:
  - mode localparams MODE_MANUAL=2'd0, MODE_AUTO=2'd1, MODE_HOLD=2'd2;
  - a function computing the next enabled index and its wrap flag from (cur, mask).
- One sub-module, scan_next_sel: combinational next-enabled-channel finder (inputs cur_sel, en_mask; outputs next_sel, wrap, any_en), parametrised by CHANNELS.
- The top module holds the registers, the mode decode and the data-select mux.

Test Plan:
1. Reset then MANUAL, CHANNELS=8, WIDTH=1, data_in=8'b1010_0110, en_mask=8'hFF, sel_in=1 → one edge later data_out=1, sel_out=1, valid_out=1. Then sel_in=0 → data_out=0, sel_out=0, valid_out=1.
2. MANUAL, en_mask=8'hFD, sel_in=1 → data_out=0, valid_out=0. With CHANNELS=6, sel_in=7 → valid_out=0, data_out=0.
3. AUTO, dwell=2, en_mask=8'b0010_0101, starting from cur_sel=0 → sel_out follows 0,0,0,2,2,2,5,5,5,0… with a one-cycle lag; wrap_out=1 exactly on the edge where cur_sel goes 5→0.
4. AUTO, dwell=0, en_mask=8'h10 → cur_sel stays 4, wrap_out=1 every cycle, valid_out=1. Then en_mask=0 → valid_out=0, data_out=0, wrap_out=0.
5. AUTO, dwell=3, assert HOLD for 5 cycles mid-dwell, then return to AUTO → outputs frozen during HOLD; the remaining dwell count completes exactly as before the hold.
6. AUTO mid-scan at cur_sel=5, dwell_cnt=1, assert rst for 1 cycle → next cycle all outputs 0. After rst is released in AUTO, the scan restarts at channel 0.
